// File: rtl/neuron_sched.sv
// Round-robin scheduler and phase sequencer for one neuron datapath.
// Grants one requester, replays its weight through load/sum/update pulses and reports the spike.
module neuron_sched #(
  parameter int n_req       = 4,
  parameter int data_bits   = 4,
  parameter int refr_cycles = 0,
  localparam int src_bits   = (n_req > 1) ? $clog2(n_req) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [n_req-1:0]             req,
  input  logic [n_req*data_bits-1:0]   req_data,
  output logic [n_req-1:0]             grant,
  output logic [data_bits-1:0]         neuron_data_in,
  output logic [4:0]                   ctrl_vec,
  input  logic                         spike_in,
  output logic                         spike_valid,
  output logic                         spike,
  output logic [src_bits-1:0]          spike_src,
  output logic                         busy
);

  localparam int cnt_bits = (refr_cycles > 1) ? $clog2(refr_cycles) : 1;
  localparam logic [cnt_bits-1:0] refr_load =
    cnt_bits'((refr_cycles > 0) ? refr_cycles - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, SETUP, LOAD, GAP1, SUM, GAP2, UPD, SETTLE, REPORT, REFRACT
  } state_t;

  state_t state_q, state_d;

  logic [src_bits-1:0]  ptr_q, ptr_d, idx_q, win_idx;
  logic                 win_found, take;
  logic [n_req-1:0]     grant_q, grant_d;
  logic [data_bits-1:0] hold_q;
  logic [4:0]           ctrl_q, ctrl_d;
  logic                 spike_valid_q, spike_q, busy_q;
  logic [src_bits-1:0]  spike_src_q;
  logic [cnt_bits-1:0]  refr_q;

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    int j;
    logic [src_bits-1:0] jj;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < n_req; i++) begin
      j = int'(ptr_q) + i;
      if (j >= n_req) j = j - n_req;
      jj = src_bits'(j);
      if (!win_found && req[jj]) begin
        win_found = 1'b1;
        win_idx   = jj;
      end
    end
  end

  assign take = (state_q == IDLE) && en && win_found;

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = '0;
    if (take) begin
      grant_d = n_req'(1) << win_idx;
      if (n_req == 1 || int'(win_idx) == n_req - 1) ptr_d = '0;
      else ptr_d = win_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = SETUP;
      SETUP:   state_d = LOAD;
      LOAD:    state_d = GAP1;
      GAP1:    state_d = SUM;
      SUM:     state_d = GAP2;
      GAP2:    state_d = UPD;
      UPD:     state_d = SETTLE;
      SETTLE:  state_d = REPORT;
      REPORT:  state_d = (spike_in && (refr_cycles > 0)) ? REFRACT : IDLE;
      REFRACT: if (refr_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state register by one cycle.
  always_comb begin
    ctrl_d = 5'b00000;
    case (state_q)
      LOAD:    ctrl_d = 5'b00011;
      SUM:     ctrl_d = 5'b00100;
      UPD:     ctrl_d = 5'b11000;
      default: ctrl_d = 5'b00000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      grant_q       <= '0;
      hold_q        <= '0;
      ctrl_q        <= 5'b00000;
      spike_valid_q <= 1'b0;
      spike_q       <= 1'b0;
      spike_src_q   <= '0;
      busy_q        <= 1'b0;
      refr_q        <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      ctrl_q        <= ctrl_d;
      busy_q        <= (state_q != IDLE) || take;
      spike_valid_q <= (state_q == REPORT);
      if (take) begin
        hold_q <= req_data[int'(win_idx)*data_bits +: data_bits];
        idx_q  <= win_idx;
      end
      if (state_q == REPORT) begin
        spike_q     <= spike_in;
        spike_src_q <= idx_q;
      end
      if (state_q == REPORT && state_d == REFRACT) refr_q <= refr_load;
      else if (state_q == REFRACT && refr_q != '0) refr_q <= refr_q - 1'b1;
    end
  end

  assign grant          = grant_q;
  assign neuron_data_in = hold_q;
  assign ctrl_vec       = ctrl_q;
  assign spike_valid    = spike_valid_q;
  assign spike          = spike_q;
  assign spike_src      = spike_src_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_neuron_sched.sv
// Directed bench for neuron_sched: two instances (no refractory / four refractory cycles),
// each driving a small behavioural neuron datapath with threshold 8.
module tb_neuron_sched;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        spike_in, r_spike_in;

  logic [3:0]  grant, r_grant;
  logic [3:0]  ndi, r_ndi;
  logic [4:0]  ctrl, r_ctrl;
  logic        sv, r_sv, spk, r_spk, busy, r_busy;
  logic [1:0]  src, r_src;

  int checks   = 0;
  int failures = 0;

  neuron_sched #(.n_req(4), .data_bits(4), .refr_cycles(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .grant(grant), .neuron_data_in(ndi), .ctrl_vec(ctrl), .spike_in(spike_in),
    .spike_valid(sv), .spike(spk), .spike_src(src), .busy(busy)
  );

  neuron_sched #(.n_req(4), .data_bits(4), .refr_cycles(4)) u_dut_r (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .grant(r_grant), .neuron_data_in(r_ndi), .ctrl_vec(r_ctrl), .spike_in(r_spike_in),
    .spike_valid(r_sv), .spike(r_spk), .spike_src(r_src), .busy(r_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural neuron: load latches the weight, sum accumulates clamped at 0, update fires above 8.
  int w0, p0, w1, p1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w0 <= 0; p0 <= 0; spike_in <= 1'b0;
    end else begin
      if (ctrl == 5'b00011) w0 <= int'($signed(ndi));
      if (ctrl == 5'b00100) p0 <= (p0 + w0 < 0) ? 0 : p0 + w0;
      if (ctrl == 5'b11000) begin
        if (p0 > 8) begin spike_in <= 1'b1; p0 <= 0; end
        else spike_in <= 1'b0;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w1 <= 0; p1 <= 0; r_spike_in <= 1'b0;
    end else begin
      if (r_ctrl == 5'b00011) w1 <= int'($signed(r_ndi));
      if (r_ctrl == 5'b00100) p1 <= (p1 + w1 < 0) ? 0 : p1 + w1;
      if (r_ctrl == 5'b11000) begin
        if (p1 > 8) begin r_spike_in <= 1'b1; p1 <= 0; end
        else r_spike_in <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d, input logic e);
    req      = r;
    req_data = d;
    en       = e;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] expCtrl(input int k);
    case (k)
      2:       return 5'b00011;
      4:       return 5'b00100;
      6:       return 5'b11000;
      default: return 5'b00000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    tick();
    tick();
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_ctrl", 32'(ctrl), 32'h0);
    checkOutput("reset_ndi", 32'(ndi), 32'h0);
    checkOutput("reset_sv", 32'(sv), 32'h0);
    checkOutput("reset_spike", 32'(spk), 32'h0);
    checkOutput("reset_src", 32'(src), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);

    $display("[TB] single event from source 0, weight 3");
    applyStimulus(4'b0001, 16'h0003, 1'b1);
    rst = 1'b0;
    tick();
    for (int k = 0; k <= 8; k++) begin
      checkOutput($sformatf("s1_grant_k%0d", k), 32'(grant), (k == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("s1_ctrl_k%0d", k), 32'(ctrl), 32'(expCtrl(k)));
      checkOutput($sformatf("s1_sv_k%0d", k), 32'(sv), (k == 8) ? 32'h1 : 32'h0);
      checkOutput($sformatf("s1_busy_k%0d", k), 32'(busy), 32'h1);
      if (k == 0) req = 4'b0000;
      if (k == 1) checkOutput("s1_ndi", 32'(ndi), 32'h3);
      if (k == 8) begin
        checkOutput("s1_spike", 32'(spk), 32'h0);
        checkOutput("s1_src", 32'(src), 32'h0);
      end
      tick();
    end
    checkOutput("s1_busy_after", 32'(busy), 32'h0);
    checkOutput("s1_grant_after", 32'(grant), 32'h0);

    $display("[TB] all four sources requesting continuously");
    applyStimulus(4'b1111, 16'h0000, 1'b1);
    applyReset();
    tick();
    for (int k = 0; k <= 36; k++) begin
      checkOutput($sformatf("s2_grant_k%0d", k), 32'(grant),
                  (k % 9 == 0) ? (32'h1 << ((k / 9) % 4)) : 32'h0);
      tick();
    end
    req = 4'b0000;

    $display("[TB] source 2 weight 5 three times, with and without refractory");
    applyStimulus(4'b0100, 16'h0500, 1'b1);
    applyReset();
    tick();
    for (int k = 0; k <= 30; k++) begin
      checkOutput($sformatf("s3_grant_k%0d", k), 32'(grant),
                  (k == 0 || k == 9 || k == 18) ? 32'h4 : 32'h0);
      checkOutput($sformatf("s3_sv_k%0d", k), 32'(sv),
                  (k == 8 || k == 17 || k == 26) ? 32'h1 : 32'h0);
      checkOutput($sformatf("s4_grant_k%0d", k), 32'(r_grant),
                  (k == 0 || k == 9 || k == 22) ? 32'h4 : 32'h0);
      checkOutput($sformatf("s4_busy_k%0d", k), 32'(r_busy), 32'h1);
      if (k == 8 || k == 17 || k == 26) begin
        checkOutput($sformatf("s3_spike_k%0d", k), 32'(spk), (k == 17) ? 32'h1 : 32'h0);
        checkOutput($sformatf("s3_src_k%0d", k), 32'(src), 32'h2);
      end
      if (k == 8 || k == 17 || k == 30) begin
        checkOutput($sformatf("s4_sv_k%0d", k), 32'(r_sv), 32'h1);
        checkOutput($sformatf("s4_spike_k%0d", k), 32'(r_spk), (k == 17) ? 32'h1 : 32'h0);
        checkOutput($sformatf("s4_src_k%0d", k), 32'(r_src), 32'h2);
      end
      if (k == 23) req = 4'b0000;
      tick();
    end

    $display("[TB] negative weight then positive weight");
    applyStimulus(4'b0001, 16'h000D, 1'b1);
    applyReset();
    tick();
    for (int k = 0; k <= 17; k++) begin
      if (k == 0) begin
        checkOutput("s5_grant0", 32'(grant), 32'h1);
        req_data = 16'h0006;
      end
      if (k == 1) checkOutput("s5_ndi_k1", 32'(ndi), 32'hD);
      if (k == 3) checkOutput("s5_ndi_k3", 32'(ndi), 32'hD);
      if (k == 8) begin
        checkOutput("s5_sv1", 32'(sv), 32'h1);
        checkOutput("s5_spike1", 32'(spk), 32'h0);
      end
      if (k == 9) begin
        checkOutput("s5_grant1", 32'(grant), 32'h1);
        checkOutput("s5_ndi_k9", 32'(ndi), 32'h6);
        req = 4'b0000;
      end
      if (k == 17) begin
        checkOutput("s5_sv2", 32'(sv), 32'h1);
        checkOutput("s5_spike2", 32'(spk), 32'h0);
      end
      tick();
    end

    $display("[TB] reset in the middle of an event");
    applyStimulus(4'b0001, 16'h0000, 1'b1);
    applyReset();
    tick();
    checkOutput("s6_grant0", 32'(grant), 32'h1);
    for (int k = 1; k <= 4; k++) tick();
    checkOutput("s6_ctrl_sum", 32'(ctrl), 32'h04);
    rst = 1'b1;
    #1;
    checkOutput("s6_rst_ctrl", 32'(ctrl), 32'h0);
    checkOutput("s6_rst_grant", 32'(grant), 32'h0);
    checkOutput("s6_rst_sv", 32'(sv), 32'h0);
    checkOutput("s6_rst_busy", 32'(busy), 32'h0);
    applyStimulus(4'b0110, 16'h0000, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("s6_first_after_rst", 32'(grant), 32'h2);

    $display("[TB] enable gating");
    applyStimulus(4'b0001, 16'h0000, 1'b0);
    applyReset();
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("s7_nogrant_%0d", k), 32'(grant), 32'h0);
      checkOutput($sformatf("s7_idle_%0d", k), 32'(busy), 32'h0);
    end
    en = 1'b1;
    tick();
    checkOutput("s7_grant", 32'(grant), 32'h1);
    en = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    checkOutput("s7_report", 32'(sv), 32'h1);
    for (int k = 9; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("s7_hold_k%0d", k), 32'(grant), 32'h0);
    end
    req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
